serial_adder: RTL and testbench
===============================

Name: serial_adder

Overview:
- Parametrised bit-serial adder. Adds two WIDTH-bit operands plus carry-in, one bit per clock, using a single full-adder cell and a carry flip-flop.
- Successor to the single-bit combinational full adder. Trades latency (WIDTH cycles) for area.
- Controlled by a start/busy/done handshake.
- Used as the arithmetic core for narrow-datapath lab designs.

Parameters:
- WIDTH, 8, operand and result width in bits; legal range 1..64.

Ports:
- clk  input  1  system clock, rising-edge active
- rst  input  1  asynchronous, active-high reset
- start  input  1  request to begin an operation; sampled on clk rising edge
- a  input  WIDTH  operand A; sampled only when start is accepted
- b  input  WIDTH  operand B; sampled only when start is accepted
- c_in  input  1  carry-in; sampled only when start is accepted
- busy  output  1  high while bits are being processed
- done  output  1  single-cycle pulse when result is valid
- sum  output  WIDTH  registered result
- c_out  output  1  registered carry-out

Behaviour:
- Interface: one clock (clk); reset rst is asynchronous and active-high.
- Reset values (rst asserted): state=IDLE, busy=0, done=0, sum=0, c_out=0, bit counter=0, internal shift registers=0, carry flop=0.
- States:
  - IDLE
  - RUN
  - DONE (one cycle only)
- IDLE: busy=0, done=0.
  - start=1 at a rising edge loads a, b, c_in into the A shift register, B shift register and carry flop.
  - Same edge: clears the bit counter and moves to RUN.
- RUN: busy=1.
  - Each edge computes s = A[0]^B[0]^carry and carry' = majority(A[0],B[0],carry).
  - s shifts into the MSB of the internal result shift register; A and B shift right; counter increments.
- Transition out of RUN: on the edge where counter reaches WIDTH-1 (the WIDTH-th processed bit):
  - The full result is transferred to sum.
  - The final carry is transferred to c_out.
  - State moves to DONE.
- DONE: done=1, busy=0, for exactly one cycle.
  - Next edge: go to RUN if start=1 (operands reloaded as in IDLE), else go to IDLE.
- Latency: start accepted at edge t0 gives done high between edges t0+WIDTH and t0+WIDTH+1. Throughput is one operation per WIDTH+1 cycles minimum.
- sum and c_out change only at completion. They hold their value through IDLE and through any subsequent RUN until the next completion.
- Arithmetic: {c_out,sum} = a + b + c_in, evaluated at WIDTH+1 bits. No saturation; wrap-around is normal modulo-2^WIDTH behaviour, with overflow reflected in c_out.
- start while in RUN: ignored; operands are not resampled.
- a/b/c_in changes after acceptance: no effect on the operation in flight.
- WIDTH=1: one RUN cycle; result equals the full-adder truth table.
- rst asserted mid-operation: immediate return to reset values. The in-flight operation is discarded and no done pulse is produced.
- Counter width: $clog2(WIDTH+1) bits; must not overflow for WIDTH=64.

Optional Feature:
- Macro: SERIAL_ADDER_SUB_EN.
- Defined:
  - Extra input port sub (1 bit), sampled with the operands when start is accepted.
  - sub=1 computes a + ~b + ~c_in: c_in acts as borrow-in, and c_out=1 means no borrow.
  - sub=0 behaves exactly as the base block.
- Not defined: no sub port; addition only.

Test Plan:
- WIDTH=8, a=8'hFF, b=8'h01, c_in=0, pulse start -> busy=1 for 8 cycles, done pulses 8 cycles after the start edge, sum=8'h00, c_out=1.
- WIDTH=8, a=8'hA5, b=8'h5A, c_in=1 -> sum=8'h00, c_out=1. Then hold start low for 5 cycles -> sum stays 8'h00, done stays 0.
- WIDTH=1, all 8 combinations of a/b/c_in -> {c_out,sum} matches the full-adder truth table (e.g. 1,1,1 -> c_out=1, sum=1), each completing 1 cycle after start.
- WIDTH=8, start with a=8'h10, b=8'h20, c_in=0. Re-pulse start with a=8'hFF at cycle 3 -> ignored; result sum=8'h30, c_out=0. Then start again during the DONE cycle with a=8'h01, b=8'h01 -> back-to-back result sum=8'h02 8 cycles later.
- WIDTH=8, start, assert rst at cycle 4 for 1 cycle -> busy=0, done=0, sum=0, c_out=0 immediately, with no done pulse afterwards. A new start after reset completes normally.
- SERIAL_ADDER_SUB_EN defined, WIDTH=8, sub=1, a=8'h05, b=8'h07, c_in=0 -> sum=8'hFE, c_out=0. Same operation with a=8'h07, b=8'h05 -> sum=8'h02, c_out=1.

Source files
------------

// File: rtl/serial_adder.sv
// Bit-serial adder: one full-adder cell plus a carry flop, WIDTH cycles per operation.
// Optional subtract mode (extra 'sub' port) is enabled by defining SERIAL_ADDER_SUB_EN.
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
`ifdef SERIAL_ADDER_SUB_EN
  input  logic             sub,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             c_out
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_e;

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_q, carry_d;
  logic             c_out_q, c_out_d;
  logic             s_bit, carry_nxt, load;
  logic [WIDTH-1:0] b_load;
  logic             c_load;

  // Subtraction is a + ~b + ~c_in, so inverting at load time keeps the datapath add-only.
`ifdef SERIAL_ADDER_SUB_EN
  assign b_load = sub ? ~b : b;
  assign c_load = sub ? ~c_in : c_in;
`else
  assign b_load = b;
  assign c_load = c_in;
`endif

  always_comb begin
    s_bit     = a_q[0] ^ b_q[0] ^ carry_q;
    carry_nxt = (a_q[0] & b_q[0]) | (a_q[0] & carry_q) | (b_q[0] & carry_q);
  end

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    carry_d = carry_q;
    sum_d   = sum_q;
    c_out_d = c_out_q;
    load    = 1'b0;

    case (state_q)
      S_IDLE: load = start;
      S_RUN: begin
        a_d     = a_q >> 1;
        b_d     = b_q >> 1;
        carry_d = carry_nxt;
        // Shift form works for WIDTH=1, where a part-select [WIDTH-1:1] would be reversed.
        res_d   = (res_q >> 1) | (WIDTH'(s_bit) << (WIDTH - 1));
        cnt_d   = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH - 1)) begin
          sum_d   = res_d;
          c_out_d = carry_nxt;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (start) load = 1'b1;
        else       state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (load) begin
      a_d     = a;
      b_d     = b_load;
      carry_d = c_load;
      cnt_d   = '0;
      state_d = S_RUN;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  // NOTE: the shift registers are plain flops, cheap to reset, so they all clear for a known state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      carry_q <= 1'b0;
      sum_q   <= '0;
      c_out_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      carry_q <= carry_d;
      sum_q   <= sum_d;
      c_out_q <= c_out_d;
    end
  end

  assign busy  = (state_q == S_RUN);
  assign done  = (state_q == S_DONE);
  assign sum   = sum_q;
  assign c_out = c_out_q;

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder: WIDTH=8 and WIDTH=1 instances, vector table,
// handshake corner sequences and randomized operations against an arithmetic model.
module tb_serial_adder;

  logic       clk = 1'b0;
  logic       rst;
  logic       start8, start1;
  logic [7:0] a8, b8;
  logic       cin8;
  logic [0:0] a1, b1;
  logic       cin1;
  logic       busy8, done8, cout8;
  logic [7:0] sum8;
  logic       busy1, done1, cout1;
  logic [0:0] sum1;
`ifdef SERIAL_ADDER_SUB_EN
  logic       sub8;
  logic       sub1;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  serial_adder #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .c_in(cin8),
`ifdef SERIAL_ADDER_SUB_EN
    .sub(sub8),
`endif
    .busy(busy8), .done(done8), .sum(sum8), .c_out(cout8)
  );

  serial_adder #(.WIDTH(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .a(a1), .b(b1), .c_in(cin1),
`ifdef SERIAL_ADDER_SUB_EN
    .sub(sub1),
`endif
    .busy(busy1), .done(done1), .sum(sum1), .c_out(cout1)
  );

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       c;
    logic [7:0] s;
    logic       co;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference: {c_out,sum} as a WIDTH+1-bit sum; subtraction is a + ~b + ~c_in.
  function automatic logic [8:0] model8(input logic [7:0] av, input logic [7:0] bv,
                                        input logic ci, input logic sb);
    logic [8:0] r;
    if (sb) r = {1'b0, av} + {1'b0, ~bv} + {8'd0, ~ci};
    else    r = {1'b0, av} + {1'b0, bv} + {8'd0, ci};
    return r;
  endfunction

  task automatic wait_done8(output int cyc, output int bsy);
    cyc = 0;
    bsy = 0;
    while (!done8 && cyc < 40) begin
      if (busy8) bsy++;
      @(negedge clk);
      cyc++;
    end
  endtask

  // One WIDTH=8 operation; operands are scrambled right after acceptance.
  task automatic op8(input logic [7:0] av, input logic [7:0] bv, input logic ci,
                     input logic [7:0] es, input logic eco, input string nm);
    int cyc, bsy;
    @(negedge clk);
    start8 = 1'b1; a8 = av; b8 = bv; cin8 = ci;
    @(negedge clk);
    start8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom);
    wait_done8(cyc, bsy);
    check({nm, " latency"}, 64'(cyc), 64'd8);
    check({nm, " busy_cycles"}, 64'(bsy), 64'd8);
    check({nm, " sum"}, 64'(sum8), 64'(es));
    check({nm, " c_out"}, 64'(cout8), 64'(eco));
    check({nm, " busy_at_done"}, 64'(busy8), 64'd0);
    @(negedge clk);
    check({nm, " done_single"}, 64'(done8), 64'd0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc, bsy, seen;
    logic [8:0] m;
    logic [1:0] e1;
    logic [7:0] ra, rb;
    logic       rc, rs;

    vecs[0] = '{a: 8'hFF, b: 8'h01, c: 1'b0, s: 8'h00, co: 1'b1};
    vecs[1] = '{a: 8'hA5, b: 8'h5A, c: 1'b1, s: 8'h00, co: 1'b1};
    vecs[2] = '{a: 8'h10, b: 8'h20, c: 1'b0, s: 8'h30, co: 1'b0};
    vecs[3] = '{a: 8'h80, b: 8'h80, c: 1'b0, s: 8'h00, co: 1'b1};
    vecs[4] = '{a: 8'h7F, b: 8'h00, c: 1'b1, s: 8'h80, co: 1'b0};
    vecs[5] = '{a: 8'hFF, b: 8'hFF, c: 1'b1, s: 8'hFF, co: 1'b1};

    rst = 1'b1; start8 = 1'b0; start1 = 1'b0;
    a8 = '0; b8 = '0; cin8 = 1'b0; a1 = '0; b1 = '0; cin1 = 1'b0;
`ifdef SERIAL_ADDER_SUB_EN
    sub8 = 1'b0; sub1 = 1'b0;
`endif
    repeat (2) @(negedge clk);
    check("reset busy", 64'(busy8), 64'd0);
    check("reset done", 64'(done8), 64'd0);
    check("reset sum", 64'(sum8), 64'd0);
    check("reset c_out", 64'(cout8), 64'd0);
    rst = 1'b0;

    for (int i = 0; i < 6; i++)
      op8(vecs[i].a, vecs[i].b, vecs[i].c, vecs[i].s, vecs[i].co, $sformatf("vec%0d", i));

    // Idle hold after an A5+5A+1 result.
    op8(8'hA5, 8'h5A, 1'b1, 8'h00, 1'b1, "a5_5a");
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check($sformatf("idle%0d sum", i), 64'(sum8), 64'h00);
      check($sformatf("idle%0d done", i), 64'(done8), 64'd0);
    end

    // WIDTH=1 full-adder truth table.
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      start1 = 1'b1; a1 = 1'(i >> 2); b1 = 1'(i >> 1); cin1 = 1'(i);
      e1 = 2'(a1) + 2'(b1) + 2'(cin1);
      @(negedge clk);
      start1 = 1'b0;
      cyc = 0;
      while (!done1 && cyc < 10) begin @(negedge clk); cyc++; end
      check($sformatf("w1_%0d latency", i), 64'(cyc), 64'd1);
      check($sformatf("w1_%0d result", i), 64'({cout1, sum1}), 64'(e1));
    end

    // start during RUN is ignored; restart in the DONE cycle runs back-to-back.
    @(negedge clk);
    start8 = 1'b1; a8 = 8'h10; b8 = 8'h20; cin8 = 1'b0;
    @(negedge clk);
    start8 = 1'b0;
    repeat (2) @(negedge clk);
    start8 = 1'b1; a8 = 8'hFF; b8 = 8'hFF; cin8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    cyc = 0;
    while (!done8 && cyc < 40) begin @(negedge clk); cyc++; end
    check("ignore sum", 64'(sum8), 64'h30);
    check("ignore c_out", 64'(cout8), 64'd0);
    start8 = 1'b1; a8 = 8'h01; b8 = 8'h01; cin8 = 1'b0;
    @(negedge clk);
    start8 = 1'b0;
    check("b2b busy", 64'(busy8), 64'd1);
    check("b2b sum_held", 64'(sum8), 64'h30);
    wait_done8(cyc, bsy);
    check("b2b latency", 64'(cyc), 64'd8);
    check("b2b sum", 64'(sum8), 64'h02);
    check("b2b c_out", 64'(cout8), 64'd0);

    // Reset in the middle of an operation.
    @(negedge clk);
    start8 = 1'b1; a8 = 8'hF0; b8 = 8'h33; cin8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    check("midrst busy", 64'(busy8), 64'd0);
    check("midrst done", 64'(done8), 64'd0);
    check("midrst sum", 64'(sum8), 64'd0);
    check("midrst c_out", 64'(cout8), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (done8) seen++;
    end
    check("midrst no_done", 64'(seen), 64'd0);
    op8(8'h12, 8'h34, 1'b0, 8'h46, 1'b0, "post_rst");

`ifdef SERIAL_ADDER_SUB_EN
    sub8 = 1'b1;
    op8(8'h05, 8'h07, 1'b0, 8'hFE, 1'b0, "sub_5_7");
    op8(8'h07, 8'h05, 1'b0, 8'h02, 1'b1, "sub_7_5");
    sub8 = 1'b0;
`endif

    // Randomized operations against the arithmetic model.
    for (int i = 0; i < 20; i++) begin
      ra = 8'($urandom); rb = 8'($urandom); rc = 1'($urandom);
      rs = 1'b0;
`ifdef SERIAL_ADDER_SUB_EN
      rs = 1'($urandom);
      sub8 = rs;
`endif
      m = model8(ra, rb, rc, rs);
      op8(ra, rb, rc, m[7:0], m[8], $sformatf("rand%0d", i));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
